// File: rtl/mips_mem_bus_arbiter.sv
// mips_mem_bus_arbiter: shares one memory bus between instruction fetch and load/store, with lane steering and wait timeout
module mips_mem_bus_arbiter #(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter int unsigned WAIT_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;
    state_t state, state_n;
    logic own_d, we_r, last_d, grant, grant_d, mis, tout;
    logic [1:0] off, off_r;
    logic [3:0] be_n;
    logic [31:0] wd_n, cnt;
    always_comb begin
        off = d_addr[1:0];
        grant = if_req || d_req;
        grant_d = d_req && (!if_req || DATA_PRIORITY || !last_d);
        mis = grant_d && (d_size == 2'b01 ? off[0] : d_size[1] && off != 2'b00);
        be_n = !d_we ? 4'b1111 : d_size == 2'b00 ? 4'b0001 << off : d_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_n = d_size == 2'b00 ? {4{d_wdata[7:0]}} : d_size == 2'b01 ? {2{d_wdata[15:0]}} : d_wdata;
        tout = WAIT_TIMEOUT != 0 && waitrequest && cnt + 32'd1 == WAIT_TIMEOUT;
        state_n = state;
        case (state)
            IDLE:    state_n = !grant ? IDLE : mis ? RESP : ACCESS;
            ACCESS:  state_n = tout ? RESP : waitrequest ? ACCESS : we_r ? RESP : RDATA;
            RDATA:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end
    assign read = state == ACCESS && !we_r;
    assign write = state == ACCESS && we_r;
    assign if_ready = state == RESP && !own_d;
    assign d_ready = state == RESP && own_d;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            own_d <= 1'b0;
            we_r <= 1'b0;
            last_d <= 1'b1;
            off_r <= 2'b00;
            cnt <= 32'd0;
            address <= 32'd0;
            writedata <= 32'd0;
            byteenable <= 4'b0000;
            if_rdata <= 32'd0;
            d_rdata <= 32'd0;
            d_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= state == ACCESS && waitrequest ? cnt + 32'd1 : 32'd0;
            if (state == IDLE && grant) begin
                own_d <= grant_d;
                last_d <= grant_d;
                we_r <= grant_d && d_we;
                off_r <= grant_d ? off : 2'b00;
                address <= (grant_d ? d_addr : if_addr) & 32'hFFFF_FFFC;
                byteenable <= grant_d ? be_n : 4'b1111;
                writedata <= grant_d && d_we ? wd_n : 32'd0;
                if (mis) begin
                    d_rdata <= 32'd0;
                    d_err <= 1'b1;
                end
            end
            if (state == ACCESS && tout) begin
                if (own_d) begin
                    d_rdata <= 32'd0;
                    d_err <= 1'b1;
                end else begin
                    if_rdata <= 32'd0;
                end
            end
            if (state == ACCESS && !waitrequest && we_r)
                d_err <= 1'b0;
            if (state == RDATA) begin
                if (own_d) begin
                    d_rdata <= readdata >> {off_r, 3'b000};
                    d_err <= 1'b0;
                end else begin
                    if_rdata <= readdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_bus_arbiter.sv
// tb_mips_mem_bus_arbiter: directed checks of a priority/default instance and a round-robin, short-timeout instance
module tb_mips_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset, if_req, d_req, d_we, waitrequest;
    logic [1:0] d_size;
    logic [31:0] if_addr, d_addr, d_wdata, readdata;
    logic a_if_ready, a_d_ready, a_d_err, a_busy, a_write, a_read;
    logic [31:0] a_if_rdata, a_d_rdata, a_address, a_writedata;
    logic [3:0] a_be;
    logic b_if_ready, b_d_ready, b_d_err, b_busy, b_write, b_read;
    logic [31:0] b_if_rdata, b_d_rdata, b_address, b_writedata;
    logic [3:0] b_be;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mem_bus_arbiter dut_a (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ready(a_if_ready),
        .if_rdata(a_if_rdata), .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(a_d_ready), .d_rdata(a_d_rdata), .d_err(a_d_err), .busy(a_busy),
        .address(a_address), .write(a_write), .read(a_read), .waitrequest(waitrequest),
        .writedata(a_writedata), .byteenable(a_be), .readdata(readdata)
    );

    mips_mem_bus_arbiter #(.DATA_PRIORITY(1'b0), .WAIT_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ready(b_if_ready),
        .if_rdata(b_if_rdata), .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_err(b_d_err), .busy(b_busy),
        .address(b_address), .write(b_write), .read(b_read), .waitrequest(waitrequest),
        .writedata(b_writedata), .byteenable(b_be), .readdata(readdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {if_req, d_req, d_we, waitrequest} = 4'b0000;
        d_size = 2'b10;
        {if_addr, d_addr, d_wdata, readdata} = '0;
        #2;
        chk("rst_async_busy", {31'd0, a_busy}, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        chk("rst_strobes", {30'd0, a_read, a_write}, 32'd0);
        chk("rst_ready", {30'd0, a_if_ready, a_d_ready}, 32'd0);
        chk("rst_address", a_address, 32'd0);
        chk("rst_be", {28'd0, a_be}, 32'd0);
        chk("rst_rdata", a_if_rdata | a_d_rdata | {31'd0, a_d_err}, 32'd0);

        // fetch, zero wait
        if_req = 1'b1;
        if_addr = 32'hBFC0_0004;
        tick;
        chk("f_read", {31'd0, a_read}, 32'd1);
        chk("f_write", {31'd0, a_write}, 32'd0);
        chk("f_addr", a_address, 32'hBFC0_0004);
        chk("f_be", {28'd0, a_be}, 32'hF);
        chk("f_busy", {31'd0, a_busy}, 32'd1);
        tick;
        chk("f_rdata_cycle_read", {31'd0, a_read}, 32'd0);
        chk("f_rdata_cycle_rdy", {31'd0, a_if_ready}, 32'd0);
        readdata = 32'h8D09_002C;
        tick;
        chk("f_ready", {31'd0, a_if_ready}, 32'd1);
        chk("f_rdata", a_if_rdata, 32'h8D09_002C);
        chk("f_d_ready_quiet", {31'd0, a_d_ready}, 32'd0);
        if_req = 1'b0;
        readdata = 32'h0;
        tick;
        chk("f_ready_pulse", {31'd0, a_if_ready}, 32'd0);
        chk("f_idle", {31'd0, a_busy}, 32'd0);
        chk("f_rdata_hold", a_if_rdata, 32'h8D09_002C);

        // sb at offset 2
        d_req = 1'b1;
        d_we = 1'b1;
        d_size = 2'b00;
        d_addr = 32'hBFC0_0032;
        d_wdata = 32'h1234_56F3;
        tick;
        chk("sb_write", {30'd0, a_write, a_read}, 32'd2);
        chk("sb_addr", a_address, 32'hBFC0_0030);
        chk("sb_be", {28'd0, a_be}, 32'h4);
        chk("sb_wdata", a_writedata, 32'hF3F3_F3F3);
        tick;
        chk("sb_ready", {31'd0, a_d_ready}, 32'd1);
        chk("sb_err", {31'd0, a_d_err}, 32'd0);
        chk("sb_strobe_off", {31'd0, a_write}, 32'd0);
        d_req = 1'b0;
        tick;

        // sh at offset 2
        d_req = 1'b1;
        d_size = 2'b01;
        d_addr = 32'hBFC0_0036;
        d_wdata = 32'h0000_BEEF;
        tick;
        chk("sh_be", {28'd0, a_be}, 32'hC);
        chk("sh_wdata", a_writedata, 32'hBEEF_BEEF);
        tick;
        chk("sh_ready", {31'd0, a_d_ready}, 32'd1);
        d_req = 1'b0;
        tick;

        // simultaneous requests: a always D, b alternates IF,D,IF,D
        if_req = 1'b1;
        if_addr = 32'hBFC0_0023;
        d_req = 1'b1;
        d_we = 1'b0;
        d_size = 2'b10;
        d_addr = 32'hBFC0_0010;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("arb_a_addr", a_address, 32'hBFC0_0010);
            chk("arb_b_addr", b_address, (i % 2 == 0) ? 32'hBFC0_0020 : 32'hBFC0_0010);
            tick;
            readdata = 32'hA0 + i;
            tick;
            chk("arb_a_dready", {30'd0, a_if_ready, a_d_ready}, 32'd1);
            chk("arb_a_drdata", a_d_rdata, 32'hA0 + i);
            chk("arb_b_ready", {30'd0, b_if_ready, b_d_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("arb_b_rdata", (i % 2 == 0) ? b_if_rdata : b_d_rdata, 32'hA0 + i);
            if (i == 3) begin
                if_req = 1'b0;
                d_req = 1'b0;
            end
            tick;
        end

        // lw with 5 waitrequest cycles
        d_req = 1'b1;
        d_addr = 32'hBFC0_002C;
        waitrequest = 1'b1;
        tick;
        for (int k = 1; k <= 6; k++) begin
            chk("lw_wait_read", {30'd0, a_read, b_read}, 32'd3);
            chk("lw_wait_addr", a_address, 32'hBFC0_002C);
            waitrequest = k < 6;
            tick;
        end
        chk("lw_rdata_cycle", {30'd0, a_read, b_read}, 32'd0);
        readdata = 32'hCAFE_F00D;
        tick;
        chk("lw_ready", {30'd0, a_d_ready, b_d_ready}, 32'd3);
        chk("lw_rdata", a_d_rdata, 32'hCAFE_F00D);
        chk("lw_err_b", {31'd0, b_d_err}, 32'd0);
        d_req = 1'b0;
        tick;

        // lb at offset 3 shifts readdata down
        d_req = 1'b1;
        d_size = 2'b00;
        d_addr = 32'hBFC0_0033;
        tick;
        chk("lb_be", {28'd0, a_be}, 32'hF);
        tick;
        readdata = 32'h4433_2211;
        tick;
        chk("lb_rdata", a_d_rdata, 32'h44);
        d_req = 1'b0;
        tick;

        // misaligned sh at offset 1
        d_req = 1'b1;
        d_we = 1'b1;
        d_size = 2'b01;
        d_addr = 32'hBFC0_0031;
        tick;
        chk("mis_no_strobe", {30'd0, a_read, a_write}, 32'd0);
        chk("mis_ready", {31'd0, a_d_ready}, 32'd1);
        chk("mis_err", {31'd0, a_d_err}, 32'd1);
        chk("mis_rdata", a_d_rdata, 32'd0);
        d_req = 1'b0;
        tick;
        chk("mis_err_hold", {30'd0, a_d_err, a_d_ready}, 32'd2);

        // stuck waitrequest: b times out after 8 cycles, a keeps waiting
        d_req = 1'b1;
        d_we = 1'b0;
        d_size = 2'b10;
        d_addr = 32'hBFC0_0040;
        waitrequest = 1'b1;
        tick;
        for (int k = 1; k <= 8; k++) begin
            chk("to_b_read", {31'd0, b_read}, 32'd1);
            tick;
        end
        chk("to_b_dropped", {31'd0, b_read}, 32'd0);
        chk("to_b_ready", {31'd0, b_d_ready}, 32'd1);
        chk("to_b_err", {31'd0, b_d_err}, 32'd1);
        chk("to_b_rdata", b_d_rdata, 32'd0);
        chk("to_a_waiting", {30'd0, a_read, a_d_ready}, 32'd2);
        d_req = 1'b0;
        tick;

        // reset mid-ACCESS
        reset = 1'b1;
        #1;
        chk("mr_read_drop", {31'd0, a_read}, 32'd0);
        chk("mr_busy", {31'd0, a_busy}, 32'd0);
        tick;
        chk("mr_no_ready", {30'd0, a_if_ready, a_d_ready}, 32'd0);
        reset = 1'b0;
        waitrequest = 1'b0;
        if_req = 1'b1;
        if_addr = 32'hBFC0_0000;
        tick;
        chk("mr_fetch_read", {31'd0, a_read}, 32'd1);
        chk("mr_fetch_addr", a_address, 32'hBFC0_0000);
        tick;
        readdata = 32'h2408_0001;
        tick;
        chk("mr_fetch_ready", {31'd0, a_if_ready}, 32'd1);
        chk("mr_fetch_rdata", a_if_rdata, 32'h2408_0001);
        if_req = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
